// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg
// Shared types and constants for the voice allocator slice:
//   state_t  - allocator FSM states
//   event_t  - latched note event (effective on/off, note, velocity, tuning)
//   voice_t  - one voice table entry (active flag, note, allocation stamp)
// Tuning and stamp fields are sized for the largest supported parameter
// values; users keep only the low TUNING_W / AGE_W bits.
package voice_alloc_pkg;

  localparam int VIDX_W       = 8;
  localparam int MAX_TUNING_W = 64;
  localparam int MAX_AGE_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  typedef struct packed {
    logic                    on;
    logic [6:0]              note;
    logic [6:0]              velocity;
    logic [MAX_TUNING_W-1:0] tuning;
  } event_t;

  typedef struct packed {
    logic                 active;
    logic [6:0]           note;
    logic [MAX_AGE_W-1:0] stamp;
  } voice_t;

endpackage

// File: rtl/voice_alloc_table.sv
// voice_alloc_table
// Voice table storage: one voice_t entry per voice.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (clears table)
//   rd_idx / rd_entry   - combinational read port used by the scan
//   wr_en/wr_idx/wr_entry - single write port used when a command issues
//   active_map          - per-voice active bitmap
module voice_alloc_table
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  output voice_t                rd_entry,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  voice_t                wr_entry,
  output logic [NUM_VOICES-1:0] active_map
);

  voice_t entries_r [NUM_VOICES];

  // Table storage: cleared on reset, one entry written per issued command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        entries_r[i] <= '0;
      end
    end else if (wr_en) begin
      entries_r[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = entries_r[rd_idx];

  // Gather the active flags into the bitmap.
  always_comb begin
    active_map = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active_map[i] = entries_r[i].active;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice scheduler. Each accepted note event is scanned against the
// voice table one voice per cycle, then a single-cycle command is issued to
// the voice controller (or a drop pulse if nothing can be done).
// Ports:
//   i_clk, i_reset            - clock, asynchronous active-low reset
//   i_note_valid/o_note_ready - event handshake
//   i_note_on, i_note_num, i_velocity, i_tuning_code - event payload
//   o_ready_flag              - command strobe
//   o_note_status, o_voice_index, o_tuning_code, o_velocity - command (held)
//   o_voices_active           - per-voice busy bitmap
//   o_steal, o_drop           - status pulses
// Build option: define VOICE_ALLOC_STEAL_EN to steal the oldest voice when all
// voices are busy; otherwise such a note-on is dropped and o_steal is 0.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int TUNING_W   = 32,
  parameter int AGE_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_note_valid,
  output logic                  o_note_ready,
  input  logic                  i_note_on,
  input  logic [6:0]            i_note_num,
  input  logic [6:0]            i_velocity,
  input  logic [TUNING_W-1:0]   i_tuning_code,
  output logic                  o_ready_flag,
  output logic                  o_note_status,
  output logic [VIDX_W-1:0]     o_voice_index,
  output logic [TUNING_W-1:0]   o_tuning_code,
  output logic [VIDX_W-1:0]     o_velocity,
  output logic [NUM_VOICES-1:0] o_voices_active,
  output logic                  o_steal,
  output logic                  o_drop
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  state_t           state_r;
  event_t           ev_r;
  logic [IDX_W-1:0] scan_idx_r;
  logic [AGE_W-1:0] seq_r;
  logic             match_found_r, free_found_r;
  logic [IDX_W-1:0] match_idx_r, free_idx_r;
  logic             dec_wr_r;
  logic [IDX_W-1:0] dec_wr_idx_r;
  voice_t           dec_entry_r;

  voice_t           rd_entry_s;
  logic             hit_s, scan_last_s;
  logic             nx_match_found_s, nx_free_found_s;
  logic [IDX_W-1:0] nx_match_idx_s, nx_free_idx_s;
  logic             dec_cmd_s, dec_steal_s;
  logic [IDX_W-1:0] dec_idx_s;

  voice_alloc_table #(.NUM_VOICES(NUM_VOICES), .IDX_W(IDX_W)) u_table (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .rd_idx     (scan_idx_r),
    .rd_entry   (rd_entry_s),
    .wr_en      ((state_r == ST_ISSUE) && dec_wr_r),
    .wr_idx     (dec_wr_idx_r),
    .wr_entry   (dec_entry_r),
    .active_map (o_voices_active)
  );

  assign scan_last_s = (scan_idx_r == IDX_W'(NUM_VOICES - 1));

`ifdef VOICE_ALLOC_STEAL_EN
  logic             old_valid_r;
  logic [IDX_W-1:0] old_idx_r;
  logic [AGE_W-1:0] old_age_r;
  logic [AGE_W-1:0] age_s;
  logic             older_s, nx_old_valid_s;
  logic [IDX_W-1:0] nx_old_idx_s;
  logic [AGE_W-1:0] nx_old_age_s;

  // Oldest-voice tracking; modular age keeps ordering correct across seq wrap.
  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    age_s          = seq_r - rd_entry_s.stamp[AGE_W-1:0];
    older_s        = rd_entry_s.active && (!old_valid_r || (age_s > old_age_r));
    nx_old_valid_s = old_valid_r | rd_entry_s.active;
    if (older_s) begin
      nx_old_idx_s = scan_idx_r;
      nx_old_age_s = age_s;
    end else begin
      nx_old_idx_s = old_idx_r;
      nx_old_age_s = old_age_r;
    end
  end
`else
  assign o_steal = 1'b0;
`endif

  // Per-voice match/free tracking, keeping the first (lowest-index) hit.
  always_comb begin
    hit_s            = rd_entry_s.active && (rd_entry_s.note == ev_r.note);
    nx_match_found_s = match_found_r | hit_s;
    nx_free_found_s  = free_found_r | !rd_entry_s.active;
    if (hit_s && !match_found_r) begin
      nx_match_idx_s = scan_idx_r;
    end else begin
      nx_match_idx_s = match_idx_r;
    end
    if (!rd_entry_s.active && !free_found_r) begin
      nx_free_idx_s = scan_idx_r;
    end else begin
      nx_free_idx_s = free_idx_r;
    end
  end

  // Final decision from the tracking values including the last scanned voice.
  always_comb begin
    dec_cmd_s   = 1'b0;
    dec_steal_s = 1'b0;
    dec_idx_s   = '0;
    if (nx_match_found_s) begin
      dec_cmd_s = 1'b1;
      dec_idx_s = nx_match_idx_s;
    end else if (ev_r.on && nx_free_found_s) begin
      dec_cmd_s = 1'b1;
      dec_idx_s = nx_free_idx_s;
    end else if (ev_r.on) begin
`ifdef VOICE_ALLOC_STEAL_EN
      dec_cmd_s   = 1'b1;
      dec_steal_s = 1'b1;
      dec_idx_s   = nx_old_idx_s;
`else
      dec_cmd_s   = 1'b0;
`endif
    end else begin
      dec_cmd_s = 1'b0;
    end
  end

  // Allocator FSM with registered handshake, command and status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r       <= ST_IDLE;
      ev_r          <= '0;
      scan_idx_r    <= '0;
      seq_r         <= '0;
      match_found_r <= 1'b0;
      match_idx_r   <= '0;
      free_found_r  <= 1'b0;
      free_idx_r    <= '0;
      dec_wr_r      <= 1'b0;
      dec_wr_idx_r  <= '0;
      dec_entry_r   <= '0;
      o_note_ready  <= 1'b0;
      o_ready_flag  <= 1'b0;
      o_note_status <= 1'b0;
      o_voice_index <= '0;
      o_tuning_code <= '0;
      o_velocity    <= '0;
      o_drop        <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
      o_steal       <= 1'b0;
      old_valid_r   <= 1'b0;
      old_idx_r     <= '0;
      old_age_r     <= '0;
`endif
    end else begin
      o_ready_flag <= 1'b0;
      o_drop       <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
      o_steal      <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (i_note_valid && o_note_ready) begin
            // Velocity 0 note-on is a note-off.
            ev_r.on       <= i_note_on && (i_velocity != 7'd0);
            ev_r.note     <= i_note_num;
            ev_r.velocity <= i_velocity;
            ev_r.tuning   <= MAX_TUNING_W'(i_tuning_code);
            scan_idx_r    <= '0;
            match_found_r <= 1'b0;
            free_found_r  <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
            old_valid_r   <= 1'b0;
`endif
            o_note_ready  <= 1'b0;
            state_r       <= ST_SCAN;
          end else begin
            o_note_ready  <= 1'b1;
          end
        end
        ST_SCAN: begin
          match_found_r <= nx_match_found_s;
          match_idx_r   <= nx_match_idx_s;
          free_found_r  <= nx_free_found_s;
          free_idx_r    <= nx_free_idx_s;
`ifdef VOICE_ALLOC_STEAL_EN
          old_valid_r   <= nx_old_valid_s;
          old_idx_r     <= nx_old_idx_s;
          old_age_r     <= nx_old_age_s;
`endif
          scan_idx_r    <= scan_idx_r + IDX_W'(1);
          if (scan_last_s) begin
            state_r      <= ST_ISSUE;
            dec_wr_r     <= dec_cmd_s;
            dec_wr_idx_r <= dec_idx_s;
            if (dec_cmd_s) begin
              o_ready_flag  <= 1'b1;
              o_note_status <= ev_r.on;
              o_voice_index <= VIDX_W'(dec_idx_s);
`ifdef VOICE_ALLOC_STEAL_EN
              o_steal       <= dec_steal_s;
`endif
              if (ev_r.on) begin
                o_tuning_code <= ev_r.tuning[TUNING_W-1:0];
                o_velocity    <= {1'b0, ev_r.velocity};
                dec_entry_r   <= '{active: 1'b1, note: ev_r.note,
                                   stamp: MAX_AGE_W'(seq_r)};
              end else begin
                o_tuning_code <= {TUNING_W{1'b0}};
                o_velocity    <= {VIDX_W{1'b0}};
                dec_entry_r   <= '{active: 1'b0, note: ev_r.note,
                                   stamp: {MAX_AGE_W{1'b0}}};
              end
            end else begin
              o_drop <= 1'b1;
            end
          end else begin
            state_r <= ST_SCAN;
          end
        end
        ST_ISSUE: begin
          // Only a started voice consumes a sequence number.
          if (dec_wr_r && dec_entry_r.active) begin
            seq_r <= seq_r + AGE_W'(1);
          end else begin
            seq_r <= seq_r;
          end
          o_note_ready <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          o_note_ready <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // dec_steal_s is only consumed when stealing is built in.
  logic unused_s;
  assign unused_s = dec_steal_s;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NV = 16;
  localparam int TW = 32;
  localparam int AW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_note_valid = 1'b0;
  logic          o_note_ready;
  logic          i_note_on = 1'b0;
  logic [6:0]    i_note_num = 7'd0;
  logic [6:0]    i_velocity = 7'd0;
  logic [TW-1:0] i_tuning_code = '0;
  logic          o_ready_flag;
  logic          o_note_status;
  logic [7:0]    o_voice_index;
  logic [TW-1:0] o_tuning_code;
  logic [7:0]    o_velocity;
  logic [NV-1:0] o_voices_active;
  logic          o_steal;
  logic          o_drop;

  always #5 i_clk = ~i_clk;

  voice_allocator #(.NUM_VOICES(NV), .TUNING_W(TW), .AGE_W(AW)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_note_valid   (i_note_valid),
    .o_note_ready   (o_note_ready),
    .i_note_on      (i_note_on),
    .i_note_num     (i_note_num),
    .i_velocity     (i_velocity),
    .i_tuning_code  (i_tuning_code),
    .o_ready_flag   (o_ready_flag),
    .o_note_status  (o_note_status),
    .o_voice_index  (o_voice_index),
    .o_tuning_code  (o_tuning_code),
    .o_velocity     (o_velocity),
    .o_voices_active(o_voices_active),
    .o_steal        (o_steal),
    .o_drop         (o_drop)
  );

  int n_cmp = 0;
  int n_err = 0;

  // captured result of the last event
  logic          r_cmd, r_drop, r_steal, r_status;
  logic [7:0]    r_idx, r_vel;
  logic [TW-1:0] r_tun;
  int            r_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_note_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    check("ready_low_after_release", o_note_ready, 1'b0);
    @(negedge i_clk);
    check("ready_high_one_edge_later", o_note_ready, 1'b1);
  endtask

  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel,
                      input logic [TW-1:0] tun);
    int w;
    w = 0;
    while (!o_note_ready && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    if (!o_note_ready) check("ready_timeout", 1'b0, 1'b1);
    i_note_valid  = 1'b1;
    i_note_on     = on;
    i_note_num    = note;
    i_velocity    = vel;
    i_tuning_code = tun;
    @(posedge i_clk);
    #1 i_note_valid = 1'b0;
    r_cmd = 1'b0; r_drop = 1'b0; r_steal = 1'b0; r_lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge i_clk);
      if (o_ready_flag || o_drop) begin
        r_cmd    = o_ready_flag;
        r_drop   = o_drop;
        r_steal  = o_steal;
        r_status = o_note_status;
        r_idx    = o_voice_index;
        r_tun    = o_tuning_code;
        r_vel    = o_velocity;
        r_lat    = n;
        break;
      end
    end
    if (r_lat == 0) check("event_timeout", 1'b0, 1'b1);
    @(negedge i_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // ---- reset state
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", o_note_ready, 1'b0);
    check("rst_flag", o_ready_flag, 1'b0);
    check("rst_bitmap", o_voices_active, 16'h0000);
    check("rst_tuning", o_tuning_code, 32'd0);
    do_reset();

    // ---- single note-on
    send(1'b1, 7'd60, 7'd100, 32'd20000000);
    check("t1_latency", r_lat, NV + 1);
    check("t1_cmd", r_cmd, 1'b1);
    check("t1_idx", r_idx, 8'd0);
    check("t1_status", r_status, 1'b1);
    check("t1_tuning", r_tun, 32'd20000000);
    check("t1_vel", r_vel, 8'd100);
    check("t1_bitmap", o_voices_active, 16'h0001);
    check("t1_ready_back", o_note_ready, 1'b1);
    check("t1_flag_one_cycle", o_ready_flag, 1'b0);

    // ---- three notes then release middle one
    do_reset();
    send(1'b1, 7'd60, 7'd90, 32'd111);
    check("t2_idx60", r_idx, 8'd0);
    send(1'b1, 7'd62, 7'd91, 32'd222);
    check("t2_idx62", r_idx, 8'd1);
    check("t2_tun62", r_tun, 32'd222);
    send(1'b1, 7'd64, 7'd92, 32'd333);
    check("t2_idx64", r_idx, 8'd2);
    send(1'b0, 7'd62, 7'd50, 32'd444);
    check("t2_off_cmd", r_cmd, 1'b1);
    check("t2_off_idx", r_idx, 8'd1);
    check("t2_off_status", r_status, 1'b0);
    check("t2_off_tuning", r_tun, 32'd0);
    check("t2_off_vel", r_vel, 8'd0);
    check("t2_bitmap", o_voices_active, 16'h0005);

    // ---- retrigger
    do_reset();
    send(1'b1, 7'd60, 7'd100, 32'd5555);
    check("t3_first_idx", r_idx, 8'd0);
    send(1'b1, 7'd60, 7'd80, 32'd6666);
    check("t3_retrig_idx", r_idx, 8'd0);
    check("t3_retrig_steal", r_steal, 1'b0);
    check("t3_retrig_vel", r_vel, 8'd80);
    check("t3_bitmap", o_voices_active, 16'h0001);
    repeat (3) @(negedge i_clk);
    check("t3_hold_tuning", o_tuning_code, 32'd6666);
    check("t3_hold_index", o_voice_index, 8'd0);

    // ---- fill all voices, then one more note-on
    do_reset();
    for (int i = 0; i < NV; i++) begin
      send(1'b1, 7'(40 + i), 7'd64, 32'(1000 + i));
      check("t4_fill_idx", r_idx, 8'(i));
    end
    check("t4_full_bitmap", o_voices_active, 16'hFFFF);
    send(1'b1, 7'd70, 7'd64, 32'd7070);
`ifdef VOICE_ALLOC_STEAL_EN
    check("t4_steal_cmd", r_cmd, 1'b1);
    check("t4_steal_idx", r_idx, 8'd0);
    check("t4_steal_flag", r_steal, 1'b1);
    check("t4_steal_drop", r_drop, 1'b0);
`else
    check("t4_drop", r_drop, 1'b1);
    check("t4_no_cmd", r_cmd, 1'b0);
    check("t4_no_steal", r_steal, 1'b0);
    check("t4_hold_tuning", o_tuning_code, 32'd1015);
`endif
    check("t4_bitmap_after", o_voices_active, 16'hFFFF);

    // ---- unmatched note-off, velocity-0 note-on as release
    do_reset();
    send(1'b0, 7'd90, 7'd0, 32'd0);
    check("t5_drop", r_drop, 1'b1);
    check("t5_no_cmd", r_cmd, 1'b0);
    check("t5_bitmap0", o_voices_active, 16'h0000);
    send(1'b1, 7'd60, 7'd100, 32'd4242);
    check("t5_on_idx", r_idx, 8'd0);
    send(1'b1, 7'd60, 7'd0, 32'd4242);
    check("t5_vel0_cmd", r_cmd, 1'b1);
    check("t5_vel0_status", r_status, 1'b0);
    check("t5_vel0_idx", r_idx, 8'd0);
    check("t5_vel0_tuning", r_tun, 32'd0);
    check("t5_bitmap1", o_voices_active, 16'h0000);

    // ---- reset in the middle of a scan
    do_reset();
    send(1'b1, 7'd60, 7'd100, 32'd20000000);
    i_note_valid = 1'b1; i_note_on = 1'b1; i_note_num = 7'd62;
    i_velocity = 7'd70; i_tuning_code = 32'd9999;
    @(posedge i_clk);
    #1 i_note_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    i_reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (o_ready_flag || o_drop) seen = 1'b1;
    end
    check("t6_no_strobe", seen, 1'b0);
    check("t6_bitmap", o_voices_active, 16'h0000);
    check("t6_tuning", o_tuning_code, 32'd0);
    check("t6_ready", o_note_ready, 1'b0);
    i_reset = 1'b1;
    @(negedge i_clk);
    send(1'b1, 7'd61, 7'd33, 32'd1234);
    check("t6_after_idx", r_idx, 8'd0);
    check("t6_after_bitmap", o_voices_active, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the MIDI/SPI note decoder and `voice_controller`. Accepts note-on/note-off events keyed by MIDI note number, maps each to one of `NUM_VOICES` oscillator voices (retrigger, first-free, or oldest-steal), and drives the `voice_controller` command port (`note_status`, `voice_index`, `tuning_code`, `velocity`, `ready_flag`) with one single-cycle command per resolved event.

## Interface
- `NUM_VOICES`, 16: voice count, 2..256.
- `TUNING_W`, 32: DDS tuning code width.
- `AGE_W`, 16: allocation sequence counter width.
- `i_clk` in 1: system clock.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_note_valid` in 1: event present.
- `o_note_ready` out 1: block can accept an event. Transfer occurs when `i_note_valid && o_note_ready` on a rising edge.
- `i_note_on` in 1: 1 = note-on, 0 = note-off.
- `i_note_num` in 7: MIDI note number.
- `i_velocity` in 7: MIDI velocity.
- `i_tuning_code` in TUNING_W: precomputed tuning for `i_note_num`.
- `o_ready_flag` out 1: one-cycle command strobe to `voice_controller`.
- `o_note_status` out 1: 1 = start voice, 0 = release voice.
- `o_voice_index` out 8: target voice.
- `o_tuning_code` out TUNING_W: command tuning code.
- `o_velocity` out 8: zero-extended velocity.
- `o_voices_active` out NUM_VOICES: per-voice busy bitmap.
- `o_steal` out 1: pulses with `o_ready_flag` when the command overrides a busy voice holding a different note.
- `o_drop` out 1: one-cycle pulse when an accepted event produces no command.

## Operation
- Voice table, one entry per voice: `active`, `note[6:0]`, `stamp[AGE_W-1:0]`. Global `seq` counter (AGE_W).
- Note-on with `i_velocity == 0` is treated as note-off.
- Accepted events are latched. FSM states:
  - IDLE: `o_note_ready = 1`. On accept, go to SCAN.
  - SCAN: examines voice `i = 0..NUM_VOICES-1`, one per cycle, then goes to ISSUE.
  - ISSUE: drives the command or the drop, updates the table, then returns to IDLE.
- Note-on selection priority:
  1. Active voice with the same note (retrigger).
  2. Lowest-index inactive voice.
  3. Active voice with maximum age, where `age = seq - stamp` (mod 2^AGE_W, wrap-safe). Ties go to the lowest index.
- Note-on in ISSUE:
  - Set `active = 1`, `note`, `stamp = seq`.
  - Increment `seq`, wrapping.
  - Emit `note_status = 1` with the latched tuning and velocity.
- Note-off:
  - Lowest-index active voice with a matching note is selected.
  - In ISSUE: clear `active`, emit `note_status = 0`, `tuning_code = 0`, `velocity = 0`.
  - No match: `o_drop` pulse and no `o_ready_flag`.
- `o_voices_active` reflects the table directly and updates on the ISSUE edge.

## Timing
- Reset values:
  - All outputs 0, including `o_note_ready`.
  - Table cleared, `seq = 0`, state IDLE.
  - `o_note_ready` rises on the first clock edge after reset is released.
- Event accepted at edge k:
  - SCAN occupies cycles k+1 .. k+NUM_VOICES.
  - `o_ready_flag`, command outputs, and `o_steal`/`o_drop` are registered and valid for exactly cycle k+NUM_VOICES+1.
  - `o_note_ready` is high again at cycle k+NUM_VOICES+2.
- Throughput: one event per NUM_VOICES+2 cycles.
- Command outputs other than `o_ready_flag` hold their last values between strobes.
- `i_note_valid` while `o_note_ready = 0` is ignored. The source must hold the event until it is accepted.
- Reset asserted mid-SCAN or mid-ISSUE aborts the event with no strobe. The table is cleared.
- An `seq` wrap never causes a misordered steal while all live stamps lie within 2^AGE_W - 1 allocations.

## Configuration
- `VOICE_ALLOC_STEAL_EN` defined: priority 3 (oldest-voice steal) is enabled and `o_steal` is functional.
- Macro undefined:
  - Note-on with all voices busy and no retrigger match produces `o_drop` with no command and no table change.
  - `o_steal` is tied to 0.
  - Age comparison logic is omitted.

## Structure
- Package `voice_alloc_pkg` holds:
  - FSM state enum (IDLE, SCAN, ISSUE).
  - Latched event struct (on, note, velocity, tuning).
  - Voice entry struct.
  - Voice-index width constant (8).
- One sub-module, `voice_alloc_table`. It holds the voice table and register array and exposes the per-index read plus the write port used in ISSUE. The scan/priority tracking stays in the top level.

## Test plan
- Reset, then note-on note 60, vel 100, tuning 20000000 → strobe at accept+NUM_VOICES+1 with voice 0, status 1, tuning 20000000, vel 100; `o_voices_active = 16'h0001`.
- Note-on 60, 62, 64, then note-off 62 → commands go to voices 0, 1, 2, then status 0 to voice 1; bitmap `16'h0005`.
- Note-on 60 twice → both commands target voice 0 (retrigger); `o_steal = 0`; bitmap `16'h0001`.
- Fill all 16 voices with notes 40..55, then note-on 70:
  - With macro: voice 0, `o_steal = 1`.
  - Without macro: `o_drop = 1`, no strobe.
- Note-off note 90 with no voice holding it, and note-on note 60 vel 0 after note 60 is playing → first gives `o_drop` only; second releases voice 0.
- Assert reset at SCAN cycle 5 → no strobe, all outputs 0; after release, the next note-on is allocated to voice 0.
